data_mem: RTL and testbench

Word-organised data memory for the single-cycle RV32I core, sitting directly downstream of the ALU. The ALU result is the byte address for loads and stores. Loads are combinational and return sign- or zero-extended byte/halfword/word data to the writeback mux. Stores are synchronous with byte-lane masking. Misaligned, out-of-range and illegal accesses are suppressed and counted.

---
 rtl/data_mem.sv | 143 ++++++++++++++
 tb/tb_data_mem.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Word-organised RV32I data memory: combinational sign/zero-extending loads,
// byte-lane masked synchronous stores, with fault detection and counting.
module data_mem #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic        RE,
  input  logic [2:0]  funct3,
  output logic [31:0] RD,
  output logic        Fault,
  output logic        FaultSticky,
  output logic [7:0]  FaultCount
);

  logic [31:0]   r_mem [DEPTH];
  logic          r_sticky;
  logic [7:0]    r_count;

  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic [31:0]   w_word;
  logic          w_oor;
  logic          w_mis;
  logic          w_illegal;
  logic          w_fault;
  logic          w_store;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rd;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wdata;

  assign w_idx  = A[AW+1:2];
  assign w_off  = A[1:0];
  assign w_word = r_mem[w_idx];
  assign w_oor  = |A[31:AW+2];

  // Alignment and legality of the requested access
  always_comb begin
    w_mis     = 1'b0;
    w_illegal = 1'b0;
    case (funct3)
      3'b001, 3'b101: w_mis = A[0];
      3'b010:         w_mis = (w_off != 2'd0);
      default:        w_mis = 1'b0;
    endcase
    case (funct3)
      3'b011, 3'b110, 3'b111: w_illegal = RE | WE;
      3'b100, 3'b101:         w_illegal = WE;
      default:                w_illegal = 1'b0;
    endcase
    if (WE && RE) begin
      w_illegal = 1'b1;
    end else begin
      w_illegal = w_illegal;
    end
  end

  assign w_fault = (RE | WE) & (w_oor | w_mis | w_illegal);
  assign w_store = WE & ~RE & ~w_fault;

  // Load path: lane select then extension; zero unless a clean load
  always_comb begin
    w_byte = w_word[8*w_off +: 8];
    w_half = A[1] ? w_word[31:16] : w_word[15:0];
    w_rd   = 32'd0;
    if (RE && !WE && !w_fault) begin
      case (funct3)
        3'b000:  w_rd = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_rd = {24'd0, w_byte};
        3'b001:  w_rd = {{16{w_half[15]}}, w_half};
        3'b101:  w_rd = {16'd0, w_half};
        3'b010:  w_rd = w_word;
        default: w_rd = 32'd0;
      endcase
    end else begin
      w_rd = 32'd0;
    end
  end

  // Store lane mask with data replicated into every lane
  always_comb begin
    w_wmask = 4'd0;
    w_wdata = 32'd0;
    case (funct3)
      3'b000: begin
        w_wmask = 4'b0001 << w_off;
        w_wdata = {4{WD[7:0]}};
      end
      3'b001: begin
        w_wmask = A[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD[15:0]}};
      end
      3'b010: begin
        w_wmask = 4'b1111;
        w_wdata = WD;
      end
      default: begin
        w_wmask = 4'd0;
        w_wdata = 32'd0;
      end
    endcase
  end

  // Memory array with async clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Sticky fault flag and saturating fault counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= 1'b0;
      r_count  <= 8'd0;
    end else if (w_fault) begin
      r_sticky <= 1'b1;
      if (r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign RD          = w_rd;
  assign Fault       = w_fault;
  assign FaultSticky = r_sticky;
  assign FaultCount  = r_count;

endmodule

// File: tb/tb_data_mem.sv
// Directed table-driven bench for data_mem with hand-computed expectations.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic        RE;
  logic [2:0]  funct3;
  logic [31:0] RD;
  logic        Fault;
  logic        FaultSticky;
  logic [7:0]  FaultCount;

  int total;
  int bad;
  int exp_cnt;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  data_mem #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .A(A), .WD(WD), .WE(WE), .RE(RE),
    .funct3(funct3), .RD(RD), .Fault(Fault),
    .FaultSticky(FaultSticky), .FaultCount(FaultCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic re, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic flt);
    vec_t v;
    v.we = we; v.re = re; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.flt = flt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    WE = we; RE = re; funct3 = f3; A = a; WD = wd;
  endtask

  initial begin
    total = 0; bad = 0; exp_cnt = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    //   we    re    f3      A              WD             RD             Fault
    add(1'b0, 1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0);
    add(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    add(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
    add(1'b1, 1'b0, 3'b000, 32'h0000_0011, 32'h0000_00AA, 32'h0000_0000, 1'b0);
    add(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_AAEF, 1'b0);
    add(1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_0000, 32'hFFFF_FFAA, 1'b0);
    add(1'b0, 1'b1, 3'b100, 32'h0000_0011, 32'h0000_0000, 32'h0000_00AA, 1'b0);
    add(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_DEAD, 1'b0);
    add(1'b0, 1'b1, 3'b101, 32'h0000_0012, 32'h0000_0000, 32'h0000_DEAD, 1'b0);
    add(1'b0, 1'b1, 3'b000, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFEF, 1'b0);
    add(1'b0, 1'b1, 3'b100, 32'h0000_0013, 32'h0000_0000, 32'h0000_00DE, 1'b0);
    add(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'hFFFF_1234, 32'h0000_0000, 1'b0);
    add(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'h1234_AAEF, 1'b0);
    add(1'b0, 1'b1, 3'b001, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_AAEF, 1'b0);
    add(1'b1, 1'b0, 3'b010, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    add(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'h1234_AAEF, 1'b0);
    add(1'b0, 1'b1, 3'b001, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 1'b0);
    add(1'b0, 1'b1, 3'b011, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1'b1, 1'b0, 3'b100, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'h1234_AAEF, 1'b0);
    add(1'b0, 1'b0, 3'b110, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0);
    add(1'b1, 1'b0, 3'b010, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0);
    add(1'b0, 1'b1, 3'b010, 32'h0000_00FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0);
    add(1'b0, 1'b1, 3'b101, 32'h0000_00FE, 32'h0000_0000, 32'h0000_CAFE, 1'b0);
    add(1'b1, 1'b0, 3'b010, 32'h0000_00FD, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].a, vecs[i].wd);
      #1;
      chk($sformatf("vec%0d_rd", i), RD, vecs[i].rd);
      chk($sformatf("vec%0d_fault", i), {31'd0, Fault}, {31'd0, vecs[i].flt});
      chk($sformatf("vec%0d_cnt", i), {24'd0, FaultCount}, exp_cnt);
      chk($sformatf("vec%0d_sticky", i), {31'd0, FaultSticky}, {31'd0, exp_cnt != 0});
      if (vecs[i].flt) exp_cnt++;
    end

    // Saturation: a long run of out-of-range loads
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'd0);
      #1;
      if (exp_cnt == 254 || exp_cnt == 255)
        chk($sformatf("sat_cnt_%0d", i), {24'd0, FaultCount}, exp_cnt);
      if (exp_cnt < 255) exp_cnt++;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    chk("sat_hold", {24'd0, FaultCount}, 32'h0000_00FF);
    chk("sat_sticky", {31'd0, FaultSticky}, 32'd1);

    // Async reset mid-cycle while a store is pending
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h1234_5678);
    #2 reset = 1'b1;
    #1;
    chk("async_sticky", {31'd0, FaultSticky}, 32'd0);
    chk("async_cnt", {24'd0, FaultCount}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'd0);
    #1;
    chk("rst_load_zero", RD, 32'd0);
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'd0);
    #1;
    chk("rst_fault_comb", {31'd0, Fault}, 32'd1);
    @(negedge clk);
    #1;
    chk("rst_no_count", {24'd0, FaultCount}, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'd0);
    #1;
    chk("lost_store", RD, 32'd0);
    drive(1'b0, 1'b1, 3'b010, 32'h0000_00FC, 32'd0);
    #1;
    chk("cleared_word", RD, 32'd0);
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    chk("post_rst_cnt", {24'd0, FaultCount}, 32'd1);
    chk("post_rst_sticky", {31'd0, FaultSticky}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
